present_block_ctrl: RTL and testbench
=====================================

Name: present_block_ctrl

Overview:
- Block-level sequencer for the `present` cipher core.
- Accepts 64-bit blocks over a valid/ready stream and latches the key, direction and chaining mode per block.
- Drives the core's reset and input ports, waits for the core's key-generation and completion flags, and returns results over a valid/ready output stream.
- Supports ECB and CBC chaining with a caller-loaded IV; sits between a bus/DMA front end and one `present` instance.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles allowed in WAIT_KEY + WAIT_CIPHER combined before the error exit.
- CNT_WIDTH, 8, width of the watchdog counter; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- key  in  80  cipher key, sampled on input handshake.
- enc_dec  in  1  0 = encrypt, 1 = decrypt, sampled on input handshake.
- cbc  in  1  1 = CBC, 0 = ECB, sampled on input handshake.
- iv_load  in  1  single-cycle strobe: chain register <= iv. Accepted only in IDLE; ignored otherwise.
- iv  in  64  initialisation vector.
- in_valid  in  1  input block valid.
- in_ready  out  1  input block accepted.
- in_block  in  64  plaintext (encrypt) or ciphertext (decrypt).
- out_valid  out  1  result valid.
- out_ready  in  1  result consumer ready.
- out_block  out  64  result block.
- out_error  out  1  qualifies out_valid: the watchdog expired, out_block = 0.
- busy  out  1  high in any state except IDLE.
- core_rst  out  1  to present.rst.
- core_key  out  80  to present.key.
- core_enc_dec  out  1  to present.enc_dec.
- core_block_i  out  64  to present.block_i.
- core_end_key  in  1  from present.end_key_generation.
- core_block_o  in  64  from present.block_o.
- core_end  in  1  from present.end_signal.

Behaviour:
- Reset values:
  - state = IDLE.
  - in_ready = 1; out_valid = 0; out_error = 0; out_block = 0; busy = 0.
  - core_rst = 1, so the core is held in reset while idle.
  - Chain register = 0; latched key / enc_dec / cbc / block = 0.
- States: IDLE, CORE_RST, WAIT_KEY, WAIT_CIPHER, OUTPUT.
- IDLE:
  - in_ready = 1 and core_rst = 1.
  - On in_valid: latch key, enc_dec, cbc and in_block, then go to CORE_RST.
  - If iv_load and in_valid are high in the same cycle, the IV is written first; that block uses the new IV.
- CORE_RST:
  - Exactly one cycle with core_rst = 1 and the latched inputs already on the core ports.
  - Clear the watchdog, then go to WAIT_KEY.
- WAIT_KEY: core_rst = 0; wait for core_end_key = 1, then go to WAIT_CIPHER.
- WAIT_CIPHER: wait for core_end = 1.
  - Then compute out_block and set out_valid = 1, out_error = 0.
  - Go to OUTPUT.
- OUTPUT:
  - Hold out_block and out_valid stable until out_ready.
  - On the handshake, clear out_valid and go to IDLE. core_rst returns to 1 in the same transition.
  - Minimum one cycle in OUTPUT, even if out_ready is already high.
- core_block_i (combinational from latched values):
  - CBC encrypt: block ^ chain.
  - Otherwise: block.
- out_block:
  - CBC decrypt: core_block_o ^ chain.
  - Otherwise: core_block_o.
- Chain update when entering OUTPUT:
  - CBC encrypt: chain <= core_block_o.
  - CBC decrypt: chain <= latched input block.
  - ECB: chain unchanged.
- Watchdog:
  - Increments every cycle in WAIT_KEY and WAIT_CIPHER.
  - When it equals TIMEOUT_CYCLES, go to OUTPUT with out_error = 1 and out_block = 0. Chain is not updated.
- Input stream: only one block in flight; in_ready = 0 in every non-IDLE state.
- Latched key / enc_dec / cbc are immune to input changes after the handshake.
- rst asserted in any state: return to reset values on the next edge and drop any in-flight block. The chain register also clears.
- Nominal latency from input handshake to out_valid is 1 + key-schedule time + cipher time + 1. The bench measures this; it is not fixed here.

Decomposition:
- present_ctrl_pkg:
  - state_t enum (3 bits).
  - Mode constants MODE_ECB / MODE_CBC.
  - Direction constants DIR_ENC / DIR_DEC.
- One sub-module, present_cbc_chain: the chain register plus the input/output XOR muxes.
  - Inputs: cbc, enc_dec, iv_load, iv, update strobe, latched block, core_block_o.
  - Outputs: core_block_i, out_block data.
- The FSM and watchdog stay in present_block_ctrl.
- The bench instantiates present_block_ctrl together with a real `present` core.

Test Plan:
- ECB encrypt:
  - Stimulus: key = 0, block = 0.
  - Response: out_block = 64'h5579C1387B228445, out_error = 0, busy low after the handshake.
- ECB decrypt:
  - Stimulus: key = 80'hFFFFFFFFFFFFFFFFFFFF, block = 64'h3333DCD3213210D2.
  - Response: out_block = 64'hFFFFFFFFFFFFFFFF.
- CBC round trip:
  - Stimulus: iv_load with iv = 64'h0123456789ABCDEF; encrypt three blocks 1, 2, 3 under key = 0. Reload the same IV and decrypt the three results.
  - Response: the decrypted blocks are 1, 2, 3, in order.
- Backpressure:
  - Stimulus: out_ready = 0 for 20 cycles while in OUTPUT.
  - Response: out_block stable, in_ready = 0, and a second in_valid is not accepted. The next block is accepted exactly one cycle after the output handshake.
- Watchdog:
  - Stimulus: core_end forced to 0.
  - Response: out_error = 1 and out_block = 0 after exactly TIMEOUT_CYCLES + 1 cycles past CORE_RST; chain unchanged.
- Reset mid-operation:
  - Stimulus: assert rst during WAIT_CIPHER.
  - Response: next edge shows out_valid = 0, core_rst = 1, in_ready = 1, and chain = 0. A subsequent ECB block gives the correct result.

Source files
------------

// File: rtl/present_ctrl_pkg.sv
// Shared types and constants for the PRESENT block sequencer and its CBC chain.
package present_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        CORE_RST    = 3'd1,
        WAIT_KEY    = 3'd2,
        WAIT_CIPHER = 3'd3,
        OUTPUT      = 3'd4
    } state_t;

    localparam logic MODE_ECB = 1'b0;
    localparam logic MODE_CBC = 1'b1;
    localparam logic DIR_ENC  = 1'b0;
    localparam logic DIR_DEC  = 1'b1;

endpackage

// File: rtl/present_cbc_chain.sv
// CBC chain register with the XOR muxes feeding the core input and forming
// the result block.
module present_cbc_chain
    import present_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cbc_i,
    input  logic        enc_dec_i,
    input  logic        iv_load_i,
    input  logic [63:0] iv_i,
    input  logic        update_i,
    input  logic [63:0] block_i,
    input  logic [63:0] core_block_o_i,
    output logic [63:0] core_block_i_o,
    output logic [63:0] out_data_o
);

    logic [63:0] chain_q;
    logic        cbcEnc;
    logic        cbcDec;

    assign cbcEnc = (cbc_i == MODE_CBC) && (enc_dec_i == DIR_ENC);
    assign cbcDec = (cbc_i == MODE_CBC) && (enc_dec_i == DIR_DEC);

    // IV load wins over a completion update; both are mutually exclusive by state anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= '0;
        end else if (iv_load_i) begin
            chain_q <= iv_i;
        end else if (update_i && (cbc_i == MODE_CBC)) begin
            chain_q <= cbcEnc ? core_block_o_i : block_i;
        end
    end

    assign core_block_i_o = cbcEnc ? (block_i ^ chain_q) : block_i;
    assign out_data_o     = cbcDec ? (core_block_o_i ^ chain_q) : core_block_o_i;

endmodule

// File: rtl/present_block_ctrl.sv
// Block-level sequencer for one PRESENT core: stream handshakes, core reset
// sequencing, ECB/CBC chaining and a completion watchdog.
module present_block_ctrl
    import present_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [79:0] key,
    input  logic        enc_dec,
    input  logic        cbc,
    input  logic        iv_load,
    input  logic [63:0] iv,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_block,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_block,
    output logic        out_error,
    output logic        busy,
    output logic        core_rst,
    output logic [79:0] core_key,
    output logic        core_enc_dec,
    output logic [63:0] core_block_i,
    input  logic        core_end_key,
    input  logic [63:0] core_block_o,
    input  logic        core_end
);

    localparam logic [CNT_WIDTH-1:0] WDOG_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   wdog_q, wdog_d;
    logic [79:0]            key_q;
    logic                   encDec_q;
    logic                   cbc_q;
    logic [63:0]            block_q;
    logic [63:0]            outBlock_q, outBlock_d;
    logic                   outValid_q, outValid_d;
    logic                   outError_q, outError_d;
    logic                   latchEn;
    logic                   chainUpdate;
    logic                   ivLoadEn;
    logic [63:0]            outData;

    assign ivLoadEn = iv_load && (state_q == IDLE);

    present_cbc_chain u_chain (
        .clk            (clk),
        .rst            (rst),
        .cbc_i          (cbc_q),
        .enc_dec_i      (encDec_q),
        .iv_load_i      (ivLoadEn),
        .iv_i           (iv),
        .update_i       (chainUpdate),
        .block_i        (block_q),
        .core_block_o_i (core_block_o),
        .core_block_i_o (core_block_i),
        .out_data_o     (outData)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wdog_q     <= '0;
            key_q      <= '0;
            encDec_q   <= DIR_ENC;
            cbc_q      <= MODE_ECB;
            block_q    <= '0;
            outBlock_q <= '0;
            outValid_q <= 1'b0;
            outError_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wdog_q     <= wdog_d;
            outBlock_q <= outBlock_d;
            outValid_q <= outValid_d;
            outError_q <= outError_d;
            if (latchEn) begin
                key_q    <= key;
                encDec_q <= enc_dec;
                cbc_q    <= cbc;
                block_q  <= in_block;
            end
        end
    end

    // The watchdog spans both wait states, so it is checked before the per-state exit.
    always_comb begin
        state_d     = state_q;
        wdog_d      = wdog_q;
        outBlock_d  = outBlock_q;
        outValid_d  = outValid_q;
        outError_d  = outError_q;
        latchEn     = 1'b0;
        chainUpdate = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    latchEn = 1'b1;
                    state_d = CORE_RST;
                end
            end
            CORE_RST: begin
                wdog_d  = '0;
                state_d = WAIT_KEY;
            end
            WAIT_KEY, WAIT_CIPHER: begin
                wdog_d = wdog_q + CNT_WIDTH'(1);
                if (wdog_q == WDOG_LIMIT) begin
                    outBlock_d = '0;
                    outValid_d = 1'b1;
                    outError_d = 1'b1;
                    state_d    = OUTPUT;
                end else if (state_q == WAIT_KEY) begin
                    if (core_end_key) begin
                        state_d = WAIT_CIPHER;
                    end
                end else if (core_end) begin
                    outBlock_d  = outData;
                    outValid_d  = 1'b1;
                    outError_d  = 1'b0;
                    chainUpdate = 1'b1;
                    state_d     = OUTPUT;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    outValid_d = 1'b0;
                    outError_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready     = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign core_rst     = (state_q == IDLE) || (state_q == CORE_RST);
    assign core_key     = key_q;
    assign core_enc_dec = encDec_q;
    assign out_valid    = outValid_q;
    assign out_block    = outBlock_q;
    assign out_error    = outError_q;

endmodule

// File: tb/tb_present_block_ctrl.sv
// Bench for present_block_ctrl driving a behavioural PRESENT-80 core, with a
// scoreboard queue of expected results and a table of block vectors.
module tb_present_block_ctrl;

    localparam int TIMEOUT     = 255;
    localparam int KEY_CYCLES  = 31;
    localparam int CIPH_CYCLES = 31;
    localparam logic [63:0] IV_A = 64'h0123456789ABCDEF;

    typedef struct {
        logic [79:0] key;
        logic        encDec;
        logic        cbc;
        logic        ivLoad;
        logic [63:0] iv;
        logic [63:0] blk;
        logic [63:0] expBlk;
        logic        expErr;
    } vec_t;

    typedef struct {
        logic [63:0] blk;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, enc_dec, cbc, iv_load, in_valid, out_ready;
    logic [79:0] key;
    logic [63:0] iv, in_block;
    logic        in_ready, out_valid, out_error, busy, core_rst, core_enc_dec;
    logic [63:0] out_block, core_block_i;
    logic [79:0] core_key;
    logic        core_end_key = 1'b0, core_end = 1'b0, forceNoEnd = 1'b0;
    logic [63:0] core_block_o = '0;
    int          coreCnt = 0;
    int          cycleCount = 0, hsCycle = 0;
    int          checks = 0, errors = 0;
    exp_t        sbQ[$];
    vec_t        vecs[9];

    always #5 clk = ~clk;
    always @(posedge clk) cycleCount <= cycleCount + 1;

    present_block_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .key(key), .enc_dec(enc_dec), .cbc(cbc),
        .iv_load(iv_load), .iv(iv), .in_valid(in_valid), .in_ready(in_ready),
        .in_block(in_block), .out_valid(out_valid), .out_ready(out_ready),
        .out_block(out_block), .out_error(out_error), .busy(busy),
        .core_rst(core_rst), .core_key(core_key), .core_enc_dec(core_enc_dec),
        .core_block_i(core_block_i), .core_end_key(core_end_key),
        .core_block_o(core_block_o), .core_end(core_end)
    );

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
            4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
            4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
            4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] invSbox4(input logic [3:0] x);
        for (int v = 0; v < 16; v++) begin
            if (sbox4(4'(v)) == x) return 4'(v);
        end
        return 4'h0;
    endfunction

    function automatic logic [63:0] sLayer(input logic [63:0] s, input bit inv);
        logic [63:0] o;
        for (int n = 0; n < 16; n++) begin
            o[n*4 +: 4] = inv ? invSbox4(s[n*4 +: 4]) : sbox4(s[n*4 +: 4]);
        end
        return o;
    endfunction

    function automatic logic [63:0] pLayer(input logic [63:0] s, input bit inv);
        logic [63:0] o;
        int p;
        o = '0;
        for (int i = 0; i < 64; i++) begin
            p = (i == 63) ? 63 : (i * 16) % 63;
            if (inv) o[i] = s[p];
            else     o[p] = s[i];
        end
        return o;
    endfunction

    // Reference PRESENT-80; dec selects the inverse cipher.
    function automatic logic [63:0] presentRef(input logic [63:0] blk, input logic [79:0] k0, input logic dec);
        logic [63:0] rk[33];
        logic [79:0] k;
        logic [63:0] s;
        k = k0;
        for (int r = 1; r <= 32; r++) begin
            rk[r] = k[79:16];
            k = {k[18:0], k[79:19]};
            k[79:76] = sbox4(k[79:76]);
            k[19:15] = k[19:15] ^ 5'(r);
        end
        if (!dec) begin
            s = blk;
            for (int r = 1; r <= 31; r++) s = pLayer(sLayer(s ^ rk[r], 1'b0), 1'b0);
            s = s ^ rk[32];
        end else begin
            s = blk ^ rk[32];
            for (int r = 31; r >= 1; r--) s = sLayer(pLayer(s, 1'b1), 1'b1) ^ rk[r];
        end
        return s;
    endfunction

    // Behavioural core: key-schedule and cipher phases with fixed lengths after reset release.
    always @(posedge clk) begin
        if (core_rst) begin
            coreCnt      <= 0;
            core_end_key <= 1'b0;
            core_end     <= 1'b0;
            core_block_o <= '0;
        end else begin
            coreCnt <= coreCnt + 1;
            if (coreCnt == KEY_CYCLES) core_end_key <= 1'b1;
            if (coreCnt == KEY_CYCLES + CIPH_CYCLES && !forceNoEnd) begin
                core_end     <= 1'b1;
                core_block_o <= presentRef(core_block_i, core_key, core_enc_dec);
            end
        end
    end

    function automatic vec_t mkVec(input logic [79:0] k, input logic ed, input logic c, input logic ivl,
                                   input logic [63:0] ivv, input logic [63:0] b, input logic [63:0] e);
        vec_t v;
        v.key = k; v.encDec = ed; v.cbc = c; v.ivLoad = ivl; v.iv = ivv;
        v.blk = b; v.expBlk = e; v.expErr = 1'b0;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input bit doPush);
        int n = 0;
        exp_t e;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("inReadyWait", 80'(in_ready), 80'(1));
        key = v.key; enc_dec = v.encDec; cbc = v.cbc; in_block = v.blk;
        iv_load = v.ivLoad; iv = v.iv; in_valid = 1'b1;
        if (doPush) begin
            e.blk = v.expBlk;
            e.err = v.expErr;
            sbQ.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        hsCycle  = cycleCount;
        in_valid = 1'b0; iv_load = 1'b0;
        key = {16'($urandom), $urandom, $urandom}; in_block = {$urandom, $urandom};
        iv = {$urandom, $urandom}; enc_dec = 1'($urandom); cbc = 1'($urandom);
    endtask

    task automatic waitOutValid(input string name);
        int n = 0;
        while (!out_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_outValidSeen"}, 80'(out_valid), 80'(1));
    endtask

    task automatic takeOutput(input string name);
        exp_t e;
        if (sbQ.size() == 0) begin
            checkOutput({name, "_scoreboardEmpty"}, 80'(sbQ.size()), 80'(1));
        end else begin
            e = sbQ.pop_front();
            checkOutput({name, "_block"}, 80'(out_block), 80'(e.blk));
            checkOutput({name, "_error"}, 80'(out_error), 80'(e.err));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({name, "_afterHs_busy_valid_ready"}, 80'({busy, out_valid, in_ready}), 80'(3'b001));
    endtask

    task automatic runVector(input vec_t v, input string name);
        applyStimulus(v, 1'b1);
        waitOutValid(name);
        takeOutput(name);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL globalTimeout: simulation did not complete");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        logic [63:0] c1, c2, c3, expB;
        vec_t v;
        c1 = presentRef(64'h1 ^ IV_A, 80'h0, 1'b0);
        c2 = presentRef(64'h2 ^ c1, 80'h0, 1'b0);
        c3 = presentRef(64'h3 ^ c2, 80'h0, 1'b0);
        vecs[0] = mkVec(80'h0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h5579C1387B228445);
        vecs[1] = mkVec({80{1'b1}}, 1'b1, 1'b0, 1'b0, 64'h0, 64'h3333DCD3213210D2, {64{1'b1}});
        vecs[2] = mkVec(80'h0, 1'b0, 1'b1, 1'b1, IV_A, 64'h1, c1);
        vecs[3] = mkVec(80'h0, 1'b0, 1'b1, 1'b0, 64'h0, 64'h2, c2);
        vecs[4] = mkVec(80'h0, 1'b0, 1'b1, 1'b0, 64'h0, 64'h3, c3);
        vecs[5] = mkVec(80'h0, 1'b1, 1'b1, 1'b1, IV_A, c1, 64'h1);
        vecs[6] = mkVec(80'h0, 1'b1, 1'b1, 1'b0, 64'h0, c2, 64'h2);
        vecs[7] = mkVec(80'h0, 1'b1, 1'b1, 1'b0, 64'h0, c3, 64'h3);
        vecs[8] = mkVec({80{1'b1}}, 1'b0, 1'b0, 1'b0, 64'h0, {64{1'b1}}, 64'h3333DCD3213210D2);

        rst = 1'b1; key = '0; enc_dec = 1'b0; cbc = 1'b0; iv_load = 1'b0; iv = '0;
        in_valid = 1'b0; in_block = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ready_valid_err_busy_crst", 80'({in_ready, out_valid, out_error, busy, core_rst}), 80'(5'b10001));
        checkOutput("reset_outBlock", 80'(out_block), 80'h0);
        checkOutput("reset_coreKey", core_key, 80'h0);
        checkOutput("reset_coreBlockI", 80'(core_block_i), 80'h0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) runVector(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: result held 20 cycles while a second block waits.
        applyStimulus(vecs[0], 1'b1);
        waitOutValid("bp");
        key = 80'h0; enc_dec = 1'b0; cbc = 1'b0; in_block = 64'h1; in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            checkOutput("bpHold_valid_ready_block", 80'({out_valid, in_ready, out_block}), 80'({1'b1, 1'b0, 64'h5579C1387B228445}));
            @(negedge clk);
        end
        takeOutput("bp");
        begin
            exp_t e;
            e.blk = presentRef(64'h1, 80'h0, 1'b0);
            e.err = 1'b0;
            sbQ.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput("bpSecondAccepted_busy_ready", 80'({busy, in_ready}), 80'(2'b10));
        in_valid = 1'b0;
        waitOutValid("bp2");
        takeOutput("bp2");

        // Watchdog: core never completes; chain must keep IV_A.
        forceNoEnd = 1'b1;
        v = mkVec(80'h0, 1'b0, 1'b1, 1'b1, IV_A, 64'h0BADC0DE, 64'h0);
        v.expErr = 1'b1;
        applyStimulus(v, 1'b1);
        waitOutValid("wdog");
        checkOutput("wdogLatency", 80'(cycleCount - hsCycle), 80'(TIMEOUT + 2));
        takeOutput("wdog");
        forceNoEnd = 1'b0;
        expB = presentRef(64'h5A5A ^ IV_A, 80'h0, 1'b0);
        runVector(mkVec(80'h0, 1'b0, 1'b1, 1'b0, 64'h0, 64'h5A5A, expB), "wdogChainKept");

        // Reset during WAIT_CIPHER with a nonzero chain.
        applyStimulus(mkVec(80'h0, 1'b0, 1'b1, 1'b1, 64'hDEADBEEF, 64'h7, 64'h0), 1'b0);
        begin
            int n = 0;
            while (!core_end_key && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        checkOutput("rstMid_keyDone", 80'(core_end_key), 80'(1));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rstMid_ready_valid_err_busy_crst", 80'({in_ready, out_valid, out_error, busy, core_rst}), 80'(5'b10001));
        checkOutput("rstMid_coreBlockI", 80'(core_block_i), 80'h0);
        rst = 1'b0;
        runVector(vecs[8], "rstMidEcb");
        expB = presentRef(64'h1, 80'h0, 1'b0);
        runVector(mkVec(80'h0, 1'b0, 1'b1, 1'b0, 64'h0, 64'h1, expB), "rstMidChainZero");

        checkOutput("scoreboardDrained", 80'(sbQ.size()), 80'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
